// File: rtl/uart_receiver_rx.sv
// ---------------------------------------------------------------------------
// uart_receiver_rx
//
// Parametrised UART receive engine. RxD is brought into the clk domain
// through a two-flop synchroniser. A falling edge on the synchronised line
// starts a frame. The start bit is checked again at mid-bit so that short
// glitches are rejected. Data bits, an optional parity bit and the stop bit
// are then sampled once per bit period at their centres.
//
// Parameters
//   CLK_FREQ    clock frequency in Hz
//   BAUD        line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD (>= 4)
//   DATA_BITS   payload bits per frame, 5..8, LSB first on the line
//   PARITY_ODD  0 = even parity, 1 = odd parity (used only with parity built)
//
// Build option
//   UART_RX_PARITY_EN  when defined, frames carry one parity bit between the
//                      data bits and the stop bit. When undefined, frames are
//                      DATA_BITS-N-1 and parity_err is tied low.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   RxD         asynchronous serial input, idles high
//   RxData      last correctly received payload, held until the next good frame
//   rx_valid    one-cycle pulse when RxData updates
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   parity_err  one-cycle pulse on a parity mismatch
//   busy        high while the receive FSM is not idle
//
// Handshake: rx_valid, frame_err and parity_err are single-cycle strobes with
// no back-pressure. Exactly one of them fires per completed frame, one cycle
// after the stop-bit sample. RxData stays stable from a rx_valid strobe until
// the next rx_valid strobe or until reset.
// ---------------------------------------------------------------------------
module uart_receiver_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = $clog2(DATA_BITS) + 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   // Elaboration-time guard on the parameter set.
   localparam bit CFG_OK = (CLKS_PER_BIT >= 4) &&
                           (DATA_BITS >= 5) && (DATA_BITS <= 8) &&
                           ((PARITY_ODD == 0) || (PARITY_ODD == 1));

   generate
      if (!CFG_OK) begin : g_bad_cfg
         $error("uart_receiver_rx: illegal parameter combination");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FSM encoding. The state register is visible as state_q for debug binds.
   // ------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   // ------------------------------------------------------------------------
   // Synchroniser and edge detector. All three flops reset to the idle
   // (high) line level, so releasing reset never fakes a start edge.
   // ------------------------------------------------------------------------
   logic rxd_meta;
   logic rxd_s;
   logic rxd_prev;
   logic fall_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= RxD;
         rxd_s    <= rxd_meta;
         rxd_prev <= rxd_s;
      end
   end

   assign fall_edge = rxd_prev & ~rxd_s;

   // ------------------------------------------------------------------------
   // FSM and datapath registers
   // ------------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [IDX_W-1:0]       idx_q,   idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q,  data_d;
   logic                   rv_q,    rv_d;
   logic                   fe_q,    fe_d;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_SENSE = (PARITY_ODD != 0);
   logic                   par_bad_q, par_bad_d;
   logic                   pe_q,      pe_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         rv_q      <= 1'b0;
         fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         pe_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         rv_q      <= rv_d;
         fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         pe_q      <= pe_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      rv_d      = 1'b0;
      fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      pe_d      = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (fall_edge) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               // The line must still be low at mid start bit. Otherwise the
               // edge was a glitch and is dropped silently.
               if (!rxd_s) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               // LSB arrives first: shift in from the top so that after
               // DATA_BITS samples the first bit sits in bit 0.
               shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               par_bad_d = ((^shift_q) ^ rxd_s) != PAR_SENSE;
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               // Leaving at mid stop bit keeps half a bit of slack, so the
               // next start edge of a back-to-back frame is still caught.
               state_d = S_IDLE;
               if (!rxd_s) begin
                  fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  pe_d = 1'b1;
`endif
               end else begin
                  rv_d   = 1'b1;
                  data_d = shift_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign RxData    = data_q;
   assign rx_valid  = rv_q;
   assign frame_err = fe_q;
   assign busy      = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
